wb_unit: RTL and testbench

Writeback stage of the NPC core: accepts one retiring result per handshake from the execute stage, waits for the LSU response when the result is a load, and formats the data. It drives the register file write port (`rf_wen`/`rf_waddr`/`rf_wdata`) from registered outputs. It also exports the pending-load destination so decode can stall on RAW hazards, and reports load errors through a sticky code.

---
 rtl/wb_unit.sv | 107 ++++++++++
 tb/tb_wb_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// wb_unit: writeback stage; retires execute results, waits for and formats LSU load data,
// drives the register file write port and tracks the pending load and sticky load errors.
module wb_unit #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic [4:0]  exu_rd,
    input  logic        exu_wen,
    input  logic [31:0] exu_wdata,
    input  logic        exu_is_load,
    input  logic [2:0]  exu_funct3,
    input  logic [1:0]  exu_addr_lo,
    input  logic        lsu_rvalid,
    input  logic [31:0] lsu_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        commit,
    output logic        pend_valid,
    output logic [4:0]  pend_rd,
    output logic [1:0]  err_code,
    input  logic        err_clr
);
    typedef enum logic {IDLE, WAIT_LOAD} state_t;
    state_t      state;
    logic [15:0] cnt;
    logic        ld_wen;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_lo;
    logic [31:0] lane, ld_data;
    logic        hs, bad_f3, misal, tmo;
    logic [1:0]  new_err;

    assign exu_ready = state == IDLE;
    assign hs        = exu_valid && exu_ready;
    assign bad_f3    = exu_funct3 == 3'b011 || exu_funct3[2:1] == 2'b11;
    assign misal     = (exu_funct3[1:0] == 2'b01 && exu_addr_lo[0]) ||
                       (exu_funct3 == 3'b010 && exu_addr_lo != 2'b00);
    // lsu_rvalid takes priority over a simultaneous timeout
    assign tmo       = state == WAIT_LOAD && !lsu_rvalid && cnt == 16'(TIMEOUT - 1);
    assign lane      = lsu_rdata >> {ld_lo, 3'b000};

    always_comb begin
        new_err = hs && exu_is_load && bad_f3 ? 2'b11 :
                  hs && exu_is_load && misal  ? 2'b01 :
                  tmo                         ? 2'b10 : 2'b00;
        ld_data = ld_f3[1] ? lane :
                  ld_f3[0] ? {{16{~ld_f3[2] & lane[15]}}, lane[15:0]} :
                             {{24{~ld_f3[2] & lane[7]}}, lane[7:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ld_wen     <= 1'b0;
            ld_f3      <= '0;
            ld_lo      <= '0;
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            commit     <= 1'b0;
            pend_valid <= 1'b0;
            pend_rd    <= '0;
            err_code   <= '0;
        end else begin
            rf_wen   <= 1'b0;
            commit   <= 1'b0;
            err_code <= new_err != 2'b00 && (err_code == 2'b00 || err_clr) ? new_err :
                        err_clr ? 2'b00 : err_code;
            if (state == IDLE) begin
                if (hs && !exu_is_load) begin
                    rf_wen   <= exu_wen && exu_rd != 5'd0;
                    rf_waddr <= exu_rd;
                    rf_wdata <= exu_wdata;
                    commit   <= 1'b1;
                end else if (hs && (bad_f3 || misal)) begin
                    commit <= 1'b1;
                end else if (hs) begin
                    ld_wen     <= exu_wen;
                    ld_f3      <= exu_funct3;
                    ld_lo      <= exu_addr_lo;
                    pend_valid <= 1'b1;
                    pend_rd    <= exu_rd;
                    cnt        <= '0;
                    state      <= WAIT_LOAD;
                end
            end else if (lsu_rvalid) begin
                rf_wen     <= ld_wen && pend_rd != 5'd0;
                rf_waddr   <= pend_rd;
                rf_wdata   <= ld_data;
                commit     <= 1'b1;
                pend_valid <= 1'b0;
                state      <= IDLE;
            end else if (tmo) begin
                commit     <= 1'b1;
                pend_valid <= 1'b0;
                state      <= IDLE;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: scenario tasks for wb_unit; expected register writes go through a scoreboard queue.
module tb_wb_unit;
    logic        clk = 0, rst_n = 0;
    logic        exu_valid = 0, exu_wen = 0, exu_is_load = 0, lsu_rvalid = 0, err_clr = 0;
    logic [4:0]  exu_rd = 0;
    logic [31:0] exu_wdata = 0, lsu_rdata = 0;
    logic [2:0]  exu_funct3 = 0;
    logic [1:0]  exu_addr_lo = 0;
    logic        exu_ready, rf_wen, commit, pend_valid;
    logic [4:0]  rf_waddr, pend_rd;
    logic [31:0] rf_wdata;
    logic [1:0]  err_code;
    logic        t_ready, t_wen, t_commit, t_pend;
    logic [4:0]  t_waddr, t_pend_rd;
    logic [31:0] t_wdata;
    logic [1:0]  t_err;

    typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
    wr_t q[$];
    int total = 0, bad = 0, commits = 0;

    always #5 clk = ~clk;

    wb_unit dut (
        .clk(clk), .rst_n(rst_n), .exu_valid(exu_valid), .exu_ready(exu_ready),
        .exu_rd(exu_rd), .exu_wen(exu_wen), .exu_wdata(exu_wdata), .exu_is_load(exu_is_load),
        .exu_funct3(exu_funct3), .exu_addr_lo(exu_addr_lo), .lsu_rvalid(lsu_rvalid),
        .lsu_rdata(lsu_rdata), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .commit(commit), .pend_valid(pend_valid), .pend_rd(pend_rd), .err_code(err_code),
        .err_clr(err_clr)
    );

    wb_unit #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .exu_valid(exu_valid), .exu_ready(t_ready),
        .exu_rd(exu_rd), .exu_wen(exu_wen), .exu_wdata(exu_wdata), .exu_is_load(exu_is_load),
        .exu_funct3(exu_funct3), .exu_addr_lo(exu_addr_lo), .lsu_rvalid(lsu_rvalid),
        .lsu_rdata(lsu_rdata), .rf_wen(t_wen), .rf_waddr(t_waddr), .rf_wdata(t_wdata),
        .commit(t_commit), .pend_valid(t_pend), .pend_rd(t_pend_rd), .err_code(t_err),
        .err_clr(err_clr)
    );

    always @(negedge clk) begin
        if (commit === 1'b1) commits++;
        if (rf_wen === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got addr=%0d data=%h", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = q.pop_front();
                if ({rf_waddr, rf_wdata} !== {e.a, e.d}) begin
                    bad++;
                    $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h",
                             rf_waddr, rf_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input [2:0] f3, input [1:0] lo, input [4:0] rd,
                         input [31:0] wd);
        exu_valid = 1; exu_is_load = ld; exu_funct3 = f3; exu_addr_lo = lo;
        exu_rd = rd; exu_wen = 1; exu_wdata = wd;
    endtask

    task automatic check_q_empty(input string name);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s pending_writes got=%0d exp=0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({rf_wen, rf_waddr, rf_wdata, commit, pend_valid, pend_rd, err_code, exu_ready} !== 48'h1) begin
            bad++;
            $display("FAIL reset_state got wen=%b addr=%0d data=%h commit=%b pend=%b rd=%0d err=%b ready=%b",
                     rf_wen, rf_waddr, rf_wdata, commit, pend_valid, pend_rd, err_code, exu_ready);
        end
        step; rst_n = 1; step;
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = commits;
        drive(0, 0, 0, 5'd5, 32'h1234);        q.push_back('{5'd5, 32'h1234});
        step;
        drive(0, 0, 0, 5'd6, 32'hFFFF_0000);   q.push_back('{5'd6, 32'hFFFF_0000});
        step;
        drive(0, 0, 0, 5'd0, 32'hDEAD);
        step;
        exu_valid = 0;
        total++;
        if (rf_wen !== 1'b0 || commit !== 1'b1) begin
            bad++;
            $display("FAIL x0_write got wen=%b commit=%b exp wen=0 commit=1", rf_wen, commit);
        end
        step; step;
        total++;
        if (commits - c0 != 3) begin
            bad++;
            $display("FAIL b2b_commits got=%0d exp=3", commits - c0);
        end
        check_q_empty("b2b");
    endtask

    task automatic do_load(input [2:0] f3, input [1:0] lo, input [4:0] rd, input [31:0] rdata,
                           input int dly, input [31:0] expd);
        drive(1, f3, lo, rd, 32'h0);
        step;
        exu_valid = 0;
        for (int i = 0; i < dly; i++) begin
            total++;
            if (exu_ready !== 1'b0 || pend_valid !== 1'b1 || pend_rd !== rd) begin
                bad++;
                $display("FAIL load_wait cyc=%0d got ready=%b pend=%b rd=%0d exp ready=0 pend=1 rd=%0d",
                         i, exu_ready, pend_valid, pend_rd, rd);
            end
            if (i < dly - 1) step;
        end
        lsu_rvalid = 1; lsu_rdata = rdata;
        if (rd != 0) q.push_back('{rd, expd});
        step;
        lsu_rvalid = 0;
        total++;
        if (exu_ready !== 1'b1 || pend_valid !== 1'b0 || commit !== 1'b1) begin
            bad++;
            $display("FAIL load_done got ready=%b pend=%b commit=%b exp 1 0 1",
                     exu_ready, pend_valid, commit);
        end
        step;
    endtask

    task automatic test_formats;
        do_load(3'b000, 2'd3, 5'd1, 32'h80AB_CDEF, 1, 32'hFFFF_FF80);
        do_load(3'b100, 2'd3, 5'd2, 32'h80AB_CDEF, 1, 32'h0000_0080);
        do_load(3'b101, 2'd2, 5'd3, 32'h80AB_CDEF, 1, 32'h0000_80AB);
        do_load(3'b001, 2'd0, 5'd4, 32'h1234_8001, 2, 32'hFFFF_8001);
        check_q_empty("formats");
    endtask

    task automatic test_long_wait;
        do_load(3'b010, 2'd0, 5'd10, 32'hCAFE_F00D, 7, 32'hCAFE_F00D);
        check_q_empty("long_wait");
        err_clr = 1; step; err_clr = 0;
    endtask

    task automatic test_errors;
        drive(1, 3'b001, 2'd1, 5'd8, 32'h0);
        step;
        exu_valid = 0;
        total++;
        if (err_code !== 2'b01 || rf_wen !== 1'b0 || commit !== 1'b1 || exu_ready !== 1'b1) begin
            bad++;
            $display("FAIL misaligned got err=%b wen=%b commit=%b ready=%b exp 01 0 1 1",
                     err_code, rf_wen, commit, exu_ready);
        end
        drive(1, 3'b111, 2'd0, 5'd8, 32'h0);
        step;
        exu_valid = 0;
        total++;
        if (err_code !== 2'b01) begin
            bad++;
            $display("FAIL sticky got err=%b exp=01", err_code);
        end
        err_clr = 1; step; err_clr = 0;
        total++;
        if (err_code !== 2'b00) begin
            bad++;
            $display("FAIL err_clr got err=%b exp=00", err_code);
        end
        drive(1, 3'b011, 2'd0, 5'd9, 32'h0);
        step;
        exu_valid = 0;
        total++;
        if (err_code !== 2'b11 || rf_wen !== 1'b0) begin
            bad++;
            $display("FAIL bad_funct3 got err=%b wen=%b exp 11 0", err_code, rf_wen);
        end
        err_clr = 1; step; err_clr = 0;
        check_q_empty("errors");
    endtask

    task automatic test_timeout;
        drive(1, 3'b010, 2'd0, 5'd7, 32'h0);
        step;
        exu_valid = 0;
        step; step;
        step;
        total++;
        if (t_pend !== 1'b1 || t_ready !== 1'b0 || t_err !== 2'b00) begin
            bad++;
            $display("FAIL timeout_early got pend=%b ready=%b err=%b exp 1 0 00", t_pend, t_ready, t_err);
        end
        step;
        total++;
        if (t_err !== 2'b10 || t_pend !== 1'b0 || t_ready !== 1'b1 || t_commit !== 1'b1 || t_wen !== 1'b0) begin
            bad++;
            $display("FAIL timeout got err=%b pend=%b ready=%b commit=%b wen=%b exp 10 0 1 1 0",
                     t_err, t_pend, t_ready, t_commit, t_wen);
        end
        lsu_rvalid = 1; lsu_rdata = 32'h5555_AAAA;
        q.push_back('{5'd7, 32'h5555_AAAA});
        step;
        lsu_rvalid = 0;
        total++;
        if (t_wen !== 1'b0 || t_commit !== 1'b0 || t_err !== 2'b10) begin
            bad++;
            $display("FAIL stale_rvalid got wen=%b commit=%b err=%b exp 0 0 10", t_wen, t_commit, t_err);
        end
        step;
        check_q_empty("timeout");
        err_clr = 1; step; err_clr = 0;
    endtask

    task automatic test_reset_mid;
        drive(1, 3'b010, 2'd0, 5'd12, 32'h0);
        step;
        exu_valid = 0;
        step;
        #2 rst_n = 0;
        #1;
        total++;
        if ({rf_wen, rf_waddr, rf_wdata, commit, pend_valid, pend_rd, err_code, exu_ready} !== 48'h1) begin
            bad++;
            $display("FAIL reset_mid got wen=%b addr=%0d data=%h commit=%b pend=%b rd=%0d err=%b ready=%b",
                     rf_wen, rf_waddr, rf_wdata, commit, pend_valid, pend_rd, err_code, exu_ready);
        end
        step;
        rst_n = 1;
        step;
        lsu_rvalid = 1; lsu_rdata = 32'h1111_2222;
        step;
        lsu_rvalid = 0;
        total++;
        if (rf_wen !== 1'b0 || commit !== 1'b0 || err_code !== 2'b00) begin
            bad++;
            $display("FAIL post_reset_rvalid got wen=%b commit=%b err=%b exp 0 0 00", rf_wen, commit, err_code);
        end
        step;
        check_q_empty("reset_mid");
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_formats;
        test_long_wait;
        test_errors;
        test_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
